// File: rtl/mux_n_1_reg.sv
// N:1 registered multiplexer with valid/ready on every input and on the output.
// Optional 16-bit output-transfer counter enabled by MUX_N_1_REG_XFER_CNT_EN.
module mux_n_1_reg #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_N_1_REG_XFER_CNT_EN
  ,
  input  logic               cnt_clr,
  output logic [15:0]        xfer_cnt
`endif
);

  logic [SELW-1:0]  rr_last;
  logic             load;
  logic [N-1:0]     sel_grant;
  logic [N-1:0]     rr_grant;
  logic [N-1:0]     grant;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  grant_idx;
  int               rr_dist;
  int               rr_best_d;
  int               rr_best_i;

  assign load = ~out_valid | out_ready;

  // An out-of-range sel simply matches no input.
  always_comb begin
    sel_grant = '0;
    for (int i = 0; i < N; i++) begin
      sel_grant[i] = in_valid[i] && (sel == SELW'(i));
    end
  end

  // Round-robin: the valid input closest after rr_last (modulo N) wins.
  always_comb begin
    rr_grant  = '0;
    rr_dist   = 0;
    rr_best_d = N;
    rr_best_i = 0;
    for (int i = 0; i < N; i++) begin
      rr_dist = (i - int'(rr_last) - 1 + N) % N;
      if (in_valid[i] && (rr_dist < rr_best_d)) begin
        rr_best_d = rr_dist;
        rr_best_i = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      rr_grant[i] = (rr_best_d < N) && (rr_best_i == i);
    end
  end

  assign grant    = mode ? rr_grant : sel_grant;
  assign in_ready = grant & {N{load & rst_n}};

  always_comb begin
    grant_data = '0;
    grant_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
        grant_idx  = SELW'(i);
      end
    end
  end

  // Output register stage: loads when empty or being drained this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_last   <= SELW'(N - 1);
    end else if (load) begin
      out_valid <= |grant;
      if (|grant) begin
        out_data <= grant_data;
        out_src  <= grant_idx;
        rr_last  <= grant_idx;
      end
    end
  end

`ifdef MUX_N_1_REG_XFER_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (cnt_clr) begin
      xfer_cnt <= '0;
    end else if (out_valid & out_ready) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end
`else
  // Counter absent in this build.
`endif

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Bench for mux_n_1_reg: directed steps plus randomized traffic against a reference model.
module tb_mux_n_1_reg;
  localparam int WIDTH = 16;
  localparam int N     = 4;
  localparam int SELW  = 2;
  localparam int N3    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [SELW-1:0]    sel;
  logic               mode;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_valid;
  logic               out_ready;

  logic [N3*WIDTH-1:0] in_data_3;
  logic [N3-1:0]       in_valid_3;
  logic [N3-1:0]       in_ready_3;
  logic [SELW-1:0]     sel_3;
  logic                mode_3;
  logic [WIDTH-1:0]    out_data_3;
  logic [SELW-1:0]     out_src_3;
  logic                out_valid_3;
  logic                out_ready_3;

`ifdef MUX_N_1_REG_XFER_CNT_EN
  logic        cnt_clr;
  logic [15:0] xfer_cnt;
  logic        cnt_clr_3;
  logic [15:0] xfer_cnt_3;
`endif

  logic [WIDTH-1:0] word [N];
  always_comb begin
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = word[i];
  end

  mux_n_1_reg #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
    .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_N_1_REG_XFER_CNT_EN
    , .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt)
`endif
  );

  mux_n_1_reg #(.WIDTH(WIDTH), .N(N3), .SELW(SELW)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_3), .in_valid(in_valid_3),
    .in_ready(in_ready_3), .sel(sel_3), .mode(mode_3), .out_data(out_data_3),
    .out_src(out_src_3), .out_valid(out_valid_3), .out_ready(out_ready_3)
`ifdef MUX_N_1_REG_XFER_CNT_EN
    , .cnt_clr(cnt_clr_3), .xfer_cnt(xfer_cnt_3)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the held output word and the round-robin history.
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_src;
  int               m_rr;
  int               m_cnt;
  logic [N-1:0]     prev_valid;
  logic [N-1:0]     prev_acc;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_rr    = N - 1;
    m_cnt   = 0;
  endtask

  function automatic int exp_grant();
    int idx;
    if (mode == 1'b0) begin
      if (int'(sel) < N && ((in_valid >> sel) & 4'd1) != 4'd0) return int'(sel);
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      idx = (m_rr + k) % N;
      if (((in_valid >> idx) & 4'd1) != 4'd0) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and move the model along with the DUT.
  task automatic tick();
    int g;
    bit ld;
    bit xfer;
    g    = exp_grant();
    ld   = !m_valid || out_ready;
    xfer = m_valid && out_ready;
`ifdef MUX_N_1_REG_XFER_CNT_EN
    if (cnt_clr) m_cnt = 0;
    else if (xfer) m_cnt = (m_cnt + 1) & 16'hFFFF;
`else
    if (xfer) m_cnt = m_cnt + 1;
`endif
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = word[g];
        m_src   = g;
        m_rr    = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic cycle(input string tag);
    int g;
    logic [N-1:0] er;
    #1;
    g  = exp_grant();
    er = '0;
    if (g >= 0 && (!m_valid || out_ready)) er = 4'b0001 << g;
    prev_valid = in_valid;
    prev_acc   = in_valid & er;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, ".out_src"}, 32'(out_src), 32'(m_src));
`ifdef MUX_N_1_REG_XFER_CNT_EN
    chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
`endif
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 4'hF;
    mode        = 1'b1;
    sel         = '0;
    out_ready   = 1'b1;
    for (int i = 0; i < N; i++) word[i] = 16'(16'h1000 + i);
    in_data_3   = 48'h3333_2222_1111;
    in_valid_3  = '0;
    sel_3       = '0;
    mode_3      = 1'b0;
    out_ready_3 = 1'b1;
    prev_valid  = '0;
    prev_acc    = '0;
`ifdef MUX_N_1_REG_XFER_CNT_EN
    cnt_clr   = 1'b0;
    cnt_clr_3 = 1'b0;
`endif
    model_reset();

    // Reset held across edges with every input offering data.
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_src", 32'(out_src), 32'd0);
    rst_n = 1'b1;
    cycle("rst_rr");
    chk("rst_rr.first_src", 32'(out_src), 32'd0);

    // Explicit select of input 2.
    mode = 1'b0; sel = 2'd2; word[2] = 16'hA5A5; in_valid = 4'b0100;
    cycle("sel");
    chk("sel.out_data", 32'(out_data), 32'h0000A5A5);
    chk("sel.out_src", 32'(out_src), 32'd2);
    chk("sel.out_valid", 32'(out_valid), 32'd1);

    // Backpressure: new word waits while the held one is stalled.
    word[2] = 16'h1234; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("stall");
      chk("stall.held_data", 32'(out_data), 32'h0000A5A5);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle("unstall");
    chk("unstall.new_data", 32'(out_data), 32'h00001234);

    // Reset while an output is held discards it at once.
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.in_ready", 32'(in_ready), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;

    // Round-robin fairness.
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle("rr_all");
      chk("rr_all.seq", 32'(out_src), 32'(i % 4));
    end
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      cycle("rr_odd");
      chk("rr_odd.seq", 32'((i % 2) ? 3 : 1), 32'(out_src));
    end

    // Out-of-range select on the 3-input instance.
    in_valid = '0;
    in_valid_3 = 3'b111; sel_3 = 2'd1;
    #1;
    chk("oor.load_rdy", 32'(in_ready_3), 32'b010);
    tick();
    chk("oor.loaded_valid", 32'(out_valid_3), 32'd1);
    chk("oor.loaded_src", 32'(out_src_3), 32'd1);
    chk("oor.loaded_data", 32'(out_data_3), 32'h00002222);
    sel_3 = 2'd3;
    #1;
    chk("oor.in_ready", 32'(in_ready_3), 32'd0);
    chk("oor.still_valid", 32'(out_valid_3), 32'd1);
    tick();
    chk("oor.drained", 32'(out_valid_3), 32'd0);
    chk("oor.in_ready_idle", 32'(in_ready_3), 32'd0);
`ifdef MUX_N_1_REG_XFER_CNT_EN
    chk("oor.xfer_cnt", 32'(xfer_cnt_3), 32'd1);
`endif
    in_valid_3 = '0;

    // Randomized traffic; a source changes its word only once it is not pending.
    for (int n = 0; n < 400; n++) begin
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!prev_valid[i] || prev_acc[i]) word[i] = 16'($urandom);
      end
      cycle("rand");
    end

`ifdef MUX_N_1_REG_XFER_CNT_EN
    // Counter: clear during a transfer, count, then wrap.
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    cycle("cnt_fill");
    cnt_clr = 1'b1;
    cycle("cnt_clr");
    cnt_clr = 1'b0;
    chk("cnt.clr_with_xfer", 32'(xfer_cnt), 32'd0);
    for (int i = 0; i < 10; i++) cycle("cnt_run");
    chk("cnt.ten", 32'(xfer_cnt), 32'd10);
    for (int i = 0; i < 65525; i++) tick();
    chk("cnt.max", 32'(xfer_cnt), 32'h0000FFFF);
    cycle("cnt_wrap");
    chk("cnt.wrap", 32'(xfer_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
